// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdowns of in-flight writers drive a combinational stall.
// Optional stall statistics are compiled in with HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
   parameter int NB_REG       = 5,
   parameter int NUM_REGS     = 32,
   parameter int NB_CNT       = 3,
   parameter int LOAD_USE_GAP = 1,
   parameter int BRANCH_GAP   = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_issue_valid,
   input  logic [NB_REG-1:0] i_rs,
   input  logic [NB_REG-1:0] i_rt,
   input  logic              i_rs_used,
   input  logic              i_rt_used,
   input  logic [1:0]        i_jump_type,
   input  logic              i_wr_en,
   input  logic [NB_REG-1:0] i_wr_reg,
   input  logic              i_wr_is_load,
   output logic              o_stall,
   output logic [1:0]        o_stall_cause
`ifdef HAZARD_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]       o_cnt_lu_stalls,
   output logic [31:0]       o_cnt_br_stalls,
   output logic [7:0]        o_max_stall_run
`endif
);

   localparam logic [1:0] JT_BRANCH = 2'b01;
   localparam logic [1:0] JT_JR     = 2'b10;
   localparam logic [1:0] JT_JUMP   = 2'b11;

   // Register 0 is never tracked, so the arrays start at index 1.
   logic [NB_CNT-1:0] cnt_lu_q [1:NUM_REGS-1];
   logic [NB_CNT-1:0] cnt_lu_d [1:NUM_REGS-1];
   logic [NB_CNT-1:0] cnt_br_q [1:NUM_REGS-1];
   logic [NB_CNT-1:0] cnt_br_d [1:NUM_REGS-1];

   logic lu_rs_nz, lu_rt_nz, br_rs_nz, br_rt_nz;
   logic lu_hit, br_hit, issued;

   always_comb begin
      lu_rs_nz = 1'b0;
      lu_rt_nz = 1'b0;
      br_rs_nz = 1'b0;
      br_rt_nz = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (i_rs == NB_REG'(r)) begin
            lu_rs_nz = (cnt_lu_q[r] != '0);
            br_rs_nz = (cnt_br_q[r] != '0);
         end
         if (i_rt == NB_REG'(r)) begin
            lu_rt_nz = (cnt_lu_q[r] != '0);
            br_rt_nz = (cnt_br_q[r] != '0);
         end
      end
   end

   // Handshake: an ID instruction with i_issue_valid=1 moves on only in a cycle where o_stall=0;
   // while stalled it must be held unchanged and it leaves no trace in the scoreboard.
   always_comb begin
      lu_hit = i_issue_valid && (i_jump_type != JT_JUMP) &&
               ((i_rs_used && lu_rs_nz) || (i_rt_used && lu_rt_nz));
      br_hit = i_issue_valid &&
               (((i_jump_type == JT_BRANCH) && (br_rs_nz || br_rt_nz)) ||
                ((i_jump_type == JT_JR) && br_rs_nz));
      o_stall       = lu_hit || br_hit;
      o_stall_cause = {br_hit, lu_hit};
      issued        = i_issue_valid && !o_stall;
   end

   always_comb begin
      for (int r = 1; r < NUM_REGS; r++) begin
         cnt_lu_d[r] = (cnt_lu_q[r] != '0) ? cnt_lu_q[r] - NB_CNT'(1) : '0;
         cnt_br_d[r] = (cnt_br_q[r] != '0) ? cnt_br_q[r] - NB_CNT'(1) : '0;
         // The youngest writer replaces whatever an older producer left behind.
         if (issued && i_wr_en && (i_wr_reg == NB_REG'(r))) begin
            cnt_br_d[r] = NB_CNT'(BRANCH_GAP);
            cnt_lu_d[r] = i_wr_is_load ? NB_CNT'(LOAD_USE_GAP) : '0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            cnt_lu_q[r] <= '0;
            cnt_br_q[r] <= '0;
         end
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            cnt_lu_q[r] <= cnt_lu_d[r];
            cnt_br_q[r] <= cnt_br_d[r];
         end
      end
   end

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] lu_stalls_q, lu_stalls_d;
   logic [31:0] br_stalls_q, br_stalls_d;
   logic [7:0]  run_q, run_d;
   logic [7:0]  max_run_q, max_run_d;

   always_comb begin
      lu_stalls_d = lu_stalls_q + {31'd0, o_stall_cause[0]};
      br_stalls_d = br_stalls_q + {31'd0, o_stall_cause[1]};
      run_d       = '0;
      if (o_stall) begin
         run_d = (run_q == 8'hFF) ? 8'hFF : run_q + 8'd1;
      end
      max_run_d = (run_d > max_run_q) ? run_d : max_run_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lu_stalls_q <= '0;
         br_stalls_q <= '0;
         run_q       <= '0;
         max_run_q   <= '0;
      end else begin
         lu_stalls_q <= lu_stalls_d;
         br_stalls_q <= br_stalls_d;
         run_q       <= run_d;
         max_run_q   <= max_run_d;
      end
   end

   assign o_cnt_lu_stalls = lu_stalls_q;
   assign o_cnt_br_stalls = br_stalls_q;
   assign o_max_stall_run = max_run_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset-mid-stall sequence and random traffic
// checked against a timestamp-based model of when each register's result becomes reachable.
module tb_hazard_scoreboard;

   typedef struct {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       rs_u;
      logic       rt_u;
      logic [1:0] jt;
      logic       we;
      logic [4:0] wr;
      logic       ld;
      logic       es;
      logic [1:0] ec;
   } vec_t;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_issue_valid = 1'b0;
   logic [4:0] i_rs = '0;
   logic [4:0] i_rt = '0;
   logic       i_rs_used = 1'b0;
   logic       i_rt_used = 1'b0;
   logic [1:0] i_jump_type = '0;
   logic       i_wr_en = 1'b0;
   logic [4:0] i_wr_reg = '0;
   logic       i_wr_is_load = 1'b0;
   logic       o_stall;
   logic [1:0] o_stall_cause;
`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] o_cnt_lu_stalls;
   logic [31:0] o_cnt_br_stalls;
   logic [7:0]  o_max_stall_run;
`endif

   hazard_scoreboard dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_issue_valid (i_issue_valid),
      .i_rs          (i_rs),
      .i_rt          (i_rt),
      .i_rs_used     (i_rs_used),
      .i_rt_used     (i_rt_used),
      .i_jump_type   (i_jump_type),
      .i_wr_en       (i_wr_en),
      .i_wr_reg      (i_wr_reg),
      .i_wr_is_load  (i_wr_is_load),
      .o_stall       (o_stall),
      .o_stall_cause (o_stall_cause)
`ifdef HAZARD_SCOREBOARD_STATS_EN
      ,
      .o_cnt_lu_stalls (o_cnt_lu_stalls),
      .o_cnt_br_stalls (o_cnt_br_stalls),
      .o_max_stall_run (o_max_stall_run)
`endif
   );

   // Clock / reset
   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [2:0] exp_q[$];
   vec_t tab[$];

   // Model: the last cycle in which a consumer of each kind must still wait for register r.
   int lu_until [32];
   int br_until [32];

   task automatic model_clear();
      for (int r = 0; r < 32; r++) begin
         lu_until[r] = -1;
         br_until[r] = -1;
      end
   endtask

   task automatic model_eval(input vec_t v, output logic st, output logic [1:0] ca);
      logic lu, br;
      lu = v.v && (v.jt != 2'b11) &&
           ((v.rs_u && lu_until[v.rs] >= cyc) || (v.rt_u && lu_until[v.rt] >= cyc));
      br = v.v && ((v.jt == 2'b01 && (br_until[v.rs] >= cyc || br_until[v.rt] >= cyc)) ||
                   (v.jt == 2'b10 && br_until[v.rs] >= cyc));
      st = lu || br;
      ca = {br, lu};
   endtask

   task automatic model_issue(input vec_t v);
      if (v.we && v.wr != 5'd0) begin
         br_until[v.wr] = cyc + 3;
         lu_until[v.wr] = v.ld ? cyc + 1 : -1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Driver tasks
   task automatic drive(input vec_t v);
      i_issue_valid = v.v;
      i_rs          = v.rs;
      i_rt          = v.rt;
      i_rs_used     = v.rs_u;
      i_rt_used     = v.rt_u;
      i_jump_type   = v.jt;
      i_wr_en       = v.we;
      i_wr_reg      = v.wr;
      i_wr_is_load  = v.ld;
   endtask

   task automatic eval_cycle(input vec_t v, input bit use_tab);
      logic st;
      logic [1:0] ca;
      logic [2:0] e;
      @(negedge i_clk);
      model_eval(v, st, ca);
      exp_q.push_back({st, ca});
      e = exp_q.pop_front();
      chk("stall", {31'd0, o_stall}, {31'd0, e[2]});
      chk("cause", {30'd0, o_stall_cause}, {30'd0, e[1:0]});
      if (use_tab) begin
         chk("tab_stall", {31'd0, o_stall}, {31'd0, v.es});
         chk("tab_cause", {30'd0, o_stall_cause}, {30'd0, v.ec});
      end
      @(posedge i_clk);
      if (v.v && !st) model_issue(v);
      cyc++;
      #1;
   endtask

   task automatic run_cycle(input vec_t v, input bit use_tab);
      drive(v);
      eval_cycle(v, use_tab);
   endtask

   function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic rs_u, logic rt_u,
                               logic [1:0] jt, logic we, logic [4:0] wr, logic ld,
                               logic es, logic [1:0] ec);
      vec_t t;
      t.v = v; t.rs = rs; t.rt = rt; t.rs_u = rs_u; t.rt_u = rt_u; t.jt = jt;
      t.we = we; t.wr = wr; t.ld = ld; t.es = es; t.ec = ec;
      return t;
   endfunction

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
   endtask

   initial begin
      vec_t v;
      model_clear();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
      #12 i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // Cleared state: a branch on anything passes.
      tab.push_back(mk(1, 5, 5, 1, 1, 2'b01, 0, 0, 0, 0, 2'b00));
      // Load-use: one stall, then issue.
      tab.push_back(mk(1, 0, 0, 1, 0, 2'b00, 1, 5, 1, 0, 2'b00));
      tab.push_back(mk(1, 5, 1, 1, 1, 2'b00, 1, 6, 0, 1, 2'b01));
      tab.push_back(mk(1, 5, 1, 1, 1, 2'b00, 1, 6, 0, 0, 2'b00));
      add_idle(4);
      // ALU to ALU forwards.
      tab.push_back(mk(1, 1, 2, 1, 1, 2'b00, 1, 5, 0, 0, 2'b00));
      tab.push_back(mk(1, 5, 2, 1, 1, 2'b00, 1, 7, 0, 0, 2'b00));
      add_idle(4);
      // Branch after ALU: three stall cycles.
      tab.push_back(mk(1, 1, 2, 1, 1, 2'b00, 1, 8, 0, 0, 2'b00));
      for (int i = 0; i < 3; i++) tab.push_back(mk(1, 8, 0, 1, 1, 2'b01, 0, 0, 0, 1, 2'b10));
      tab.push_back(mk(1, 8, 0, 1, 1, 2'b01, 0, 0, 0, 0, 2'b00));
      add_idle(4);
      // jr after load: both causes first, then branch only.
      tab.push_back(mk(1, 0, 0, 1, 0, 2'b00, 1, 9, 1, 0, 2'b00));
      tab.push_back(mk(1, 9, 0, 1, 0, 2'b10, 0, 0, 0, 1, 2'b11));
      for (int i = 0; i < 2; i++) tab.push_back(mk(1, 9, 0, 1, 0, 2'b10, 0, 0, 0, 1, 2'b10));
      tab.push_back(mk(1, 9, 0, 1, 0, 2'b10, 0, 0, 0, 0, 2'b00));
      add_idle(4);
      // j after load never stalls.
      tab.push_back(mk(1, 0, 0, 1, 0, 2'b00, 1, 9, 1, 0, 2'b00));
      tab.push_back(mk(1, 9, 9, 1, 1, 2'b11, 0, 0, 0, 0, 2'b00));
      add_idle(4);
      // Writes to r0 are ignored.
      tab.push_back(mk(1, 1, 2, 1, 1, 2'b00, 1, 0, 0, 0, 2'b00));
      tab.push_back(mk(1, 0, 0, 1, 1, 2'b01, 0, 0, 0, 0, 2'b00));
      // Overwrite of a load by an ALU writer.
      tab.push_back(mk(1, 0, 0, 1, 0, 2'b00, 1, 4, 1, 0, 2'b00));
      tab.push_back(mk(1, 1, 2, 1, 1, 2'b00, 1, 4, 0, 0, 2'b00));
      tab.push_back(mk(1, 1, 2, 1, 1, 2'b00, 1, 11, 0, 0, 2'b00));
      tab.push_back(mk(1, 4, 1, 1, 1, 2'b00, 1, 10, 0, 0, 2'b00));
      add_idle(4);
      // Self-dependent load, then a non-valid slot that must not stall.
      tab.push_back(mk(1, 5, 0, 1, 0, 2'b00, 1, 5, 1, 0, 2'b00));
      tab.push_back(mk(0, 5, 5, 1, 1, 2'b01, 0, 0, 0, 0, 2'b00));
      add_idle(4);

      for (int i = 0; i < tab.size(); i++) run_cycle(tab[i], 1'b1);

      // Reset during the second branch-stall cycle.
      run_cycle(mk(1, 1, 2, 1, 1, 2'b00, 1, 8, 0, 0, 2'b00), 1'b1);
      run_cycle(mk(1, 8, 0, 1, 1, 2'b01, 0, 0, 0, 1, 2'b10), 1'b1);
      v = mk(1, 8, 0, 1, 1, 2'b01, 0, 0, 0, 0, 2'b00);
      drive(v);
      #1;
      chk("pre_rst_stall", {31'd0, o_stall}, 32'd1);
      #1 i_rst_n = 1'b0;
      #1;
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      chk("rst_cause", {30'd0, o_stall_cause}, 32'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      chk("rst_br_stats", o_cnt_br_stalls, 32'd0);
      chk("rst_lu_stats", o_cnt_lu_stalls, 32'd0);
`endif
      model_clear();
      #1 i_rst_n = 1'b1;
      eval_cycle(v, 1'b1);

      // Random traffic over a small register window to provoke hazards.
      for (int n = 0; n < 2000; n++) begin
         v = mk(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                0, 2'b00);
         run_cycle(v, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
